// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipelined CPU front end
package pipe_pkg;

    localparam logic [1:0] PCSRC_PC4 = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JR  = 2'd2;
    localparam logic [1:0] PCSRC_J   = 2'd3;

    // sll $0,$0,0 doubles as the pipeline bubble
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/mux4.sv
// rtl/mux4.sv - generic 4:1 multiplexer used for next-PC selection
module mux4
    import pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    input  logic [W-1:0] i_d3,
    input  logic [1:0]   i_s,
    output logic [W-1:0] o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_s)
            PCSRC_PC4: o_y = i_d0;
            PCSRC_BR:  o_y = i_d1;
            PCSRC_JR:  o_y = i_d2;
            PCSRC_J:   o_y = i_d3;
            default:   o_y = i_d0;
        endcase
    end

endmodule

// File: rtl/pipe_if_fetch.sv
// rtl/pipe_if_fetch.sv - IF stage: PC, req/ack instruction fetch, IF/ID register
module pipe_if_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        nostall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_dpc4;
    logic [31:0] r_inst;
    logic [31:0] r_ibuf;
    logic        r_redir_valid;
    logic [31:0] r_redir_pc;

    logic [31:0] w_pc4;
    logic [31:0] w_target;
    logic [31:0] w_npc;
    logic        w_req;
    logic        w_done;
    logic        w_advance;
    logic        w_bubble;
    logic        w_park;

    assign w_pc4 = pc_plus4(r_pc);

    mux4 #(.W(32)) u_npc_mux (
        .i_d0 (w_pc4),
        .i_d1 (bpc),
        .i_d2 (rpc),
        .i_d3 (jpc),
        .i_s  (pcsource),
        .o_y  (w_target)
    );

    // A live redirect from ID wins; otherwise replay a branch that left ID during a miss
    assign w_npc = (pcsource != PCSRC_PC4) ? w_target :
                   r_redir_valid           ? r_redir_pc : w_pc4;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: if (w_done && !nostall) w_next_state = ST_HOLD;
            ST_HOLD:  if (nostall)            w_next_state = ST_FETCH;
            default:                          w_next_state = ST_FETCH;
        endcase
    end

    always_comb begin
        w_req     = (r_state == ST_FETCH);
        w_done    = w_req & imem_ack;
        w_advance = nostall & (w_done | (r_state == ST_HOLD));
        w_bubble  = nostall & w_req & ~imem_ack;
        w_park    = w_done & ~nostall;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pc          <= RESET_PC;
            r_dpc4        <= 32'h0000_0000;
            r_inst        <= NOP_INST;
            r_ibuf        <= 32'h0000_0000;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= 32'h0000_0000;
        end else begin
            if (w_advance) begin
                r_inst        <= (r_state == ST_HOLD) ? r_ibuf : imem_rdata;
                r_dpc4        <= w_pc4;
                r_pc          <= w_npc;
                r_redir_valid <= 1'b0;
            end else if (w_bubble) begin
                r_inst <= NOP_INST;
                if (pcsource != PCSRC_PC4) begin
                    r_redir_pc    <= w_target;
                    r_redir_valid <= 1'b1;
                end
            end
            if (w_park) begin
                r_ibuf <= imem_rdata;
            end
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign dpc4      = r_dpc4;
    assign inst      = r_inst;

endmodule

// File: tb/tb_pipe_if_fetch.sv
// tb/tb_pipe_if_fetch.sv - self-checking bench for pipe_if_fetch
module tb_pipe_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        nostall = 1'b1;
    logic [1:0]  pcsource = 2'd0;
    logic [31:0] bpc = 32'h0, jpc = 32'h0, rpc = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr, pc, dpc4, inst;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_if_fetch dut (
        .clk        (clk),
        .clrn       (clrn),
        .nostall    (nostall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .rpc        (rpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ns;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] e_pc;
        logic [31:0] e_dpc4;
        logic [31:0] e_inst;
        logic        e_req;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC000_0000 ^ a;
    endfunction

    function automatic vec_t mk(input logic ns, input logic [1:0] src, input logic [31:0] tgt,
                                input logic ack, input logic [31:0] e_pc, input logic [31:0] e_dpc4,
                                input logic [31:0] e_inst, input logic e_req);
        vec_t v;
        v.ns = ns; v.src = src; v.tgt = tgt; v.ack = ack;
        v.e_pc = e_pc; v.e_dpc4 = e_dpc4; v.e_inst = e_inst; v.e_req = e_req;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_dpc4,
                             input logic [31:0] e_inst, input logic e_req);
        check32({tag, ".pc"}, pc, e_pc);
        check32({tag, ".imem_addr"}, imem_addr, e_pc);
        check32({tag, ".dpc4"}, dpc4, e_dpc4);
        check32({tag, ".inst"}, inst, e_inst);
        check32({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
    endtask

    // Unselected targets carry distinct junk so a wrong mux leg is visible
    task automatic drive(input logic ns, input logic [1:0] src, input logic [31:0] tgt, input logic ack);
        nostall  = ns;
        pcsource = src;
        bpc = 32'hBBB0_0010;
        rpc = 32'hAAA0_0020;
        jpc = 32'h5550_0030;
        case (src)
            2'd1: bpc = tgt;
            2'd2: rpc = tgt;
            2'd3: jpc = tgt;
            default: ;
        endcase
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom();
    endtask

    // reference model state
    logic [31:0] m_pc, m_dpc4, m_inst, m_park_word, m_rtgt;
    logic        m_parked, m_rv;

    task automatic model_step(input logic ns, input logic [1:0] src, input logic ack);
        logic        have_word;
        logic [31:0] word, sel;
        have_word = m_parked || ack;
        word      = m_parked ? m_park_word : imem_rdata;
        sel       = (src == 2'd1) ? bpc : (src == 2'd2) ? rpc : jpc;
        if (ns) begin
            if (have_word) begin
                m_inst   = word;
                m_dpc4   = m_pc + 32'd4;
                m_pc     = (src != 2'd0) ? sel : (m_rv ? m_rtgt : m_pc + 32'd4);
                m_rv     = 1'b0;
                m_parked = 1'b0;
            end else begin
                m_inst = NOP;
                if (src != 2'd0) begin
                    m_rv   = 1'b1;
                    m_rtgt = sel;
                end
            end
        end else if (have_word && !m_parked) begin
            m_parked    = 1'b1;
            m_park_word = word;
        end
    endtask

    initial begin
        int          lat, waited;
        logic        ns, ack, pend;
        logic [1:0]  src;
        logic [31:0] tgt, pend_addr;

        vt.push_back(mk(1, 0, 0, 1, 32'h4, 32'h4, mem_word(32'h0), 1));
        vt.push_back(mk(1, 0, 0, 1, 32'h8, 32'h8, mem_word(32'h4), 1));
        vt.push_back(mk(1, 0, 0, 1, 32'hC, 32'hC, mem_word(32'h8), 1));
        vt.push_back(mk(1, 0, 0, 1, 32'h10, 32'h10, mem_word(32'hC), 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h10, 32'h10, NOP, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h10, 32'h10, NOP, 1));
        vt.push_back(mk(1, 0, 0, 1, 32'h14, 32'h14, mem_word(32'h10), 1));
        vt.push_back(mk(1, 1, 32'h100, 1, 32'h100, 32'h18, mem_word(32'h14), 1));
        vt.push_back(mk(1, 0, 0, 1, 32'h104, 32'h104, mem_word(32'h100), 1));
        vt.push_back(mk(1, 1, 32'h200, 0, 32'h104, 32'h104, NOP, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h104, 32'h104, NOP, 1));
        vt.push_back(mk(1, 0, 0, 1, 32'h200, 32'h108, mem_word(32'h104), 1));
        vt.push_back(mk(1, 0, 0, 1, 32'h204, 32'h204, mem_word(32'h200), 1));
        vt.push_back(mk(0, 0, 0, 1, 32'h204, 32'h204, mem_word(32'h200), 0));
        vt.push_back(mk(0, 0, 0, 1, 32'h204, 32'h204, mem_word(32'h200), 0));
        vt.push_back(mk(0, 0, 0, 1, 32'h204, 32'h204, mem_word(32'h200), 0));
        vt.push_back(mk(1, 0, 0, 0, 32'h208, 32'h208, mem_word(32'h204), 1));
        vt.push_back(mk(1, 2, 32'h2000, 1, 32'h2000, 32'h20C, mem_word(32'h208), 1));
        vt.push_back(mk(1, 3, 32'h0040_0000, 1, 32'h0040_0000, 32'h2004, mem_word(32'h2000), 1));
        vt.push_back(mk(1, 3, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0040_0004, mem_word(32'h0040_0000), 1));
        vt.push_back(mk(1, 0, 0, 1, 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 1));
        vt.push_back(mk(0, 3, 32'h1234, 0, 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 1));
        vt.push_back(mk(1, 0, 0, 1, 32'h4, 32'h4, mem_word(32'h0), 1));

        repeat (2) @(negedge clk);
        check_all("reset", 32'h0, 32'h0, NOP, 1'b1);
        clrn = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].ns, vt[i].src, vt[i].tgt, vt[i].ack);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_dpc4, vt[i].e_inst, vt[i].e_req);
            @(negedge clk);
        end

        // async reset while a redirect is pending must drop both the fetch and the redirect
        drive(1, 1, 32'h300, 0);
        @(posedge clk);
        #1;
        check_all("redir_pend", 32'h4, 32'h4, NOP, 1'b1);
        @(negedge clk);
        drive(1, 0, 0, 0);
        #2 clrn = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, NOP, 1'b1);
        @(negedge clk);
        clrn = 1'b1;
        drive(1, 0, 0, 1);
        @(posedge clk);
        #1;
        check_all("post_rst", 32'h4, 32'h4, mem_word(32'h0), 1'b1);

        @(negedge clk);
        clrn = 1'b0;
        drive(1, 0, 0, 0);
        @(negedge clk);
        clrn = 1'b1;
        m_pc = 32'h0; m_dpc4 = 32'h0; m_inst = NOP; m_park_word = 32'h0;
        m_rtgt = 32'h0; m_parked = 1'b0; m_rv = 1'b0;
        lat = $urandom_range(0, 3);
        waited = 0;
        pend = 1'b0;
        pend_addr = 32'h0;

        for (int c = 0; c < 3000; c++) begin
            ns  = ($urandom_range(0, 3) != 0);
            src = m_rv ? 2'd0 : (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
            tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            ack = imem_req ? (waited >= lat) : 1'($urandom_range(0, 1));
            if (pend) check32("addr_stable", imem_addr, pend_addr);
            drive(ns, src, tgt, ack);
            pend      = imem_req && !ack;
            pend_addr = imem_addr;
            if (imem_req) begin
                if (ack) begin
                    waited = 0;
                    lat    = $urandom_range(0, 3);
                end else begin
                    waited++;
                end
            end
            model_step(ns, src, ack);
            @(posedge clk);
            #1;
            check_all("rand", m_pc, m_dpc4, m_inst, !m_parked);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
